// File: rtl/spi_ram_burst.sv
// spi_ram_burst: SPI-slave RAM; define SPI_RAM_BURST_EN for auto-increment burst transfers
module spi_ram_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);
  localparam int SW = DATA_WIDTH > ADDR_WIDTH ? DATA_WIDTH : ADDR_WIDTH;
  localparam int CW = $clog2(SW + 1);
  typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-2:0] shift_q, shift_d;
  logic [SW-1:0] shift_in;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rdata;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, rd_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, miso_q, miso_d, we;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < MEM_DEPTH;
  endfunction

  assign shift_in = {shift_q, MOSI};
  assign rd_sel   = (state_q == RD_DATA) ? inc(rd_addr_q) : rd_addr_q;
  assign rdata    = in_range(rd_sel) ? mem[rd_sel] : '0;
  assign MISO     = miso_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    miso_d    = 1'b0;
    we        = 1'b0;
    if (SS_n) begin
      state_d = IDLE;
      shift_d = '0;
      tx_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          op_d    = MOSI;
        end
        CMD: begin
          cnt_d   = '0;
          state_d = op_q ? (MOSI ? RD_DATA : RD_ADDR) : (MOSI ? WR_DATA : WR_ADDR);
          if (op_q && MOSI) begin
            miso_d = rdata[DATA_WIDTH-1];
            tx_d   = rdata << 1;
            cnt_d  = CW'(1);
          end
        end
        WR_ADDR, RD_ADDR: begin
          shift_d = shift_in[SW-2:0];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            state_d = DONE;
            if (state_q == WR_ADDR) wr_addr_d = shift_in[ADDR_WIDTH-1:0];
            else rd_addr_d = shift_in[ADDR_WIDTH-1:0];
          end
        end
        WR_DATA: begin
          shift_d = shift_in[SW-2:0];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            we = in_range(wr_addr_q);
`ifdef SPI_RAM_BURST_EN
            cnt_d     = '0;
            wr_addr_d = inc(wr_addr_q);
`else
            state_d = DONE;
`endif
          end
        end
        RD_DATA: begin
          if (cnt_q == CW'(DATA_WIDTH)) begin
`ifdef SPI_RAM_BURST_EN
            miso_d    = rdata[DATA_WIDTH-1];
            tx_d      = rdata << 1;
            cnt_d     = CW'(1);
            rd_addr_d = inc(rd_addr_q);
`else
            state_d = DONE;
            tx_d    = '0;
`endif
          end else begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      shift_q   <= '0;
      tx_q      <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      miso_q    <= miso_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr_q] <= shift_in[DATA_WIDTH-1:0];
  end
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: directed checks of a default instance and a 16/10/600 instance
module tb_spi_ram_burst;
`ifdef SPI_RAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic CLK = 1'b0, rst_n = 1'b0;
  logic ss0 = 1'b1, mosi0 = 1'b0, miso0;
  logic ss1 = 1'b1, mosi1 = 1'b0, miso1;
  int checks = 0, errors = 0;

  typedef struct {
    int u;
    bit rd;
    logic [15:0] a;
    logic [15:0] d;
  } vec_t;
  vec_t tbl [15];

  spi_ram_burst u0 (.CLK(CLK), .rst_n(rst_n), .SS_n(ss0), .MOSI(mosi0), .MISO(miso0));
  spi_ram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_DEPTH(600)) u1 (
    .CLK(CLK), .rst_n(rst_n), .SS_n(ss1), .MOSI(mosi1), .MISO(miso1));

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic ss, input logic mosi);
    if (u == 0) begin ss0 = ss; mosi0 = mosi; end
    else begin ss1 = ss; mosi1 = mosi; end
  endtask

  task automatic frame(input int u, input logic [63:0] bits, input int n, output logic [63:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      drive(u, 1'b0, bits[n-1-i]);
      @(posedge CLK);
      #1;
      cap[i] = (u == 0) ? miso0 : miso1;
    end
    @(negedge CLK);
    drive(u, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    chk("miso_idle", (u == 0) ? miso0 : miso1, 0);
  endtask

  task automatic set_addr(input int u, input bit rd, input logic [15:0] a);
    int aw;
    logic [63:0] cap;
    aw = (u == 0) ? 8 : 10;
    frame(u, (64'(rd ? 2 : 0) << aw) | 64'(a), 2 + aw, cap);
    chk("miso_addr", cap, 0);
  endtask

  task automatic wr_frame(input int u, input logic [63:0] d, input int nbits);
    logic [63:0] cap;
    frame(u, (64'(1) << nbits) | d, 2 + nbits, cap);
    chk("miso_wr", cap, 0);
  endtask

  task automatic rd_words(input int u, input int nw, output logic [63:0] w);
    int dw;
    int n;
    logic [63:0] cap;
    dw = (u == 0) ? 8 : 16;
    n = 2 + nw * dw;
    frame(u, 64'(3) << (n - 2), n, cap);
    w = '0;
    for (int j = 0; j < nw * dw; j++) w[nw*dw-1-j] = cap[1+j];
  endtask

  task automatic rd_at(input int u, input logic [15:0] a, output logic [63:0] w);
    set_addr(u, 1'b1, a);
    rd_words(u, 1, w);
  endtask

  initial begin
    logic [63:0] w;
    tbl = '{
      '{0, 1'b0, 16'h010, 16'h00A5}, '{0, 1'b1, 16'h010, 16'h00A5},
      '{0, 1'b0, 16'h000, 16'h003C}, '{0, 1'b1, 16'h000, 16'h003C},
      '{0, 1'b0, 16'h0FF, 16'h0081}, '{0, 1'b1, 16'h0FF, 16'h0081},
      '{0, 1'b1, 16'h010, 16'h00A5}, '{0, 1'b0, 16'h010, 16'h005A},
      '{0, 1'b1, 16'h010, 16'h005A},
      '{1, 1'b0, 16'h3FF, 16'hBEEF}, '{1, 1'b1, 16'h3FF, 16'h0000},
      '{1, 1'b0, 16'h257, 16'hBEEF}, '{1, 1'b1, 16'h257, 16'hBEEF},
      '{1, 1'b0, 16'h000, 16'h1234}, '{1, 1'b1, 16'h000, 16'h1234}
    };
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_miso0", miso0, 0);
    chk("reset_miso1", miso1, 0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rd) begin
        rd_at(tbl[i].u, tbl[i].a, w);
        chk($sformatf("tbl%0d_rd", i), w, 64'(tbl[i].d));
      end else begin
        set_addr(tbl[i].u, 1'b0, tbl[i].a);
        wr_frame(tbl[i].u, 64'(tbl[i].d), (tbl[i].u == 0) ? 8 : 16);
      end
    end

    set_addr(0, 1'b1, 16'h10);
    @(negedge CLK); ss0 = 1'b0; mosi0 = 1'b1; @(posedge CLK);
    @(negedge CLK); mosi0 = 1'b1; @(posedge CLK);
    @(negedge CLK); mosi0 = 1'b0; @(posedge CLK);
    #1;
    chk("rst_pre_miso", miso0, 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_miso_now", miso0, 0);
    @(negedge CLK);
    ss0 = 1'b1;
    rst_n = 1'b1;
    @(posedge CLK);
    rd_words(0, 1, w);
    chk("rst_rd_addr0", w, 64'h3C);
    rd_words(1, 1, w);
    chk("rst_rd_addr0_w", w, 64'h1234);
    wr_frame(0, 64'h9A, 8);
    rd_at(0, 16'h00, w);
    chk("rst_wr_addr0", w, 64'h9A);

    set_addr(0, 1'b0, 16'hFF); wr_frame(0, 64'hEE, 8);
    set_addr(0, 1'b0, 16'h00); wr_frame(0, 64'hDD, 8);
    set_addr(0, 1'b0, 16'hFE);
    wr_frame(0, 64'h112233, 24);
    rd_at(0, 16'hFE, w); chk("burst_wr_fe", w, 64'h11);
    rd_at(0, 16'hFF, w); chk("burst_wr_ff", w, BURST ? 64'h22 : 64'hEE);
    rd_at(0, 16'h00, w); chk("burst_wr_00", w, BURST ? 64'h33 : 64'hDD);
    set_addr(0, 1'b1, 16'hFE);
    rd_words(0, 3, w);
    chk("burst_rd", w, BURST ? 64'h112233 : 64'h110000);
    wr_frame(0, 64'h44, 8);
    rd_at(0, BURST ? 16'h01 : 16'hFE, w);
    chk("burst_wr_addr", w, 64'h44);

    set_addr(0, 1'b0, 16'h20); wr_frame(0, 64'h66, 8);
    set_addr(0, 1'b0, 16'h20);
    wr_frame(0, 64'h15, 5);
    rd_at(0, 16'h20, w); chk("abort_nowrite", w, 64'h66);
    wr_frame(0, 64'h67, 8);
    rd_at(0, 16'h20, w); chk("abort_addr_kept", w, 64'h67);
    set_addr(0, 1'b1, 16'h20);
    frame(0, 64'h18, 5, w);
    chk("abort_rd_bits", w, 64'h0C);

    set_addr(1, 1'b1, 16'h257);
    rd_words(1, 2, w);
    chk("wide_wrap", w, BURST ? 64'hBEEF1234 : 64'hBEEF0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
